lc_ram_store: RTL and testbench

Parametrised 1-read/1-write sample store for the level-check monitor, generalising the fixed 128×12 RAM wrapper to configurable width and depth. Adds a post-reset clearing sweep, registered reads with valid, read-during-write bypass, and fixed-priority arbitration between two write clients: the sampler (port A) and the bus (port B). Sits between the ADC sampler/limit logic and the management bus.

---
 rtl/lc_pkg.sv | 12 +
 rtl/lc_ram_core.sv | 33 +++
 rtl/lc_ram_store.sv | 126 ++++++++++++
 tb/tb_lc_ram_store.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc_pkg.sv
// Shared defaults and FSM state encoding for the level-check sample store.
package lc_pkg;

    localparam int unsigned LC_DATA_WIDTH = 12;
    localparam int unsigned LC_ADDR_WIDTH = 7;

    typedef enum logic {
        LC_ST_INIT  = 1'b0,
        LC_ST_READY = 1'b1
    } lc_state_e;

endpackage

// File: rtl/lc_ram_core.sv
// Plain inferred 1R1W synchronous memory: registered read, no reset on storage.
// Read-first behaviour on an address collision; the top level supplies bypass.
module lc_ram_core #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage write and registered read port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lc_ram_store.sv
// Sample store for the level-check monitor: post-reset clearing sweep,
// fixed-priority write arbitration (sampler over bus), registered reads
// with valid and read-during-write bypass.
module lc_ram_store
    import lc_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = LC_DATA_WIDTH,
    parameter int unsigned            ADDR_WIDTH = LC_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  init_done,
    input  logic                  ram_ren,
    input  logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  ram_rvalid,
    input  logic                  wa_en,
    input  logic [ADDR_WIDTH-1:0] wa_addr,
    input  logic [DATA_WIDTH-1:0] wa_data,
    output logic                  wa_ack,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_ack
);

    lc_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  rd_en;
    logic                  byp_hit;
    logic [DATA_WIDTH-1:0] core_rdata;

    logic                  rvalid_q;
    logic                  byp_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic [DATA_WIDTH-1:0] hold_q;

    // State and sweep counter register; reset restarts the sweep at address 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= LC_ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, sweep writes and write-port arbitration. Client acks are
    // also gated by reset so nothing commits on the edge that resets us.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = INIT_VALUE;
        wa_ack    = 1'b0;
        wb_ack    = 1'b0;
        case (state_q)
            LC_ST_INIT: begin
                if (reset) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == '1) begin
                        state_d = LC_ST_READY;
                    end
                end
            end
            LC_ST_READY: begin
                if (reset) begin
                    wa_ack    = wa_en;
                    wb_ack    = wb_en & ~wa_en;
                    mem_we    = wa_en | wb_en;
                    mem_waddr = wa_en ? wa_addr : wb_addr;
                    mem_wdata = wa_en ? wa_data : wb_data;
                end
            end
            default: state_d = LC_ST_INIT;
        endcase
    end

    assign init_done = (state_q == LC_ST_READY);
    assign rd_en     = (state_q == LC_ST_READY) && reset && ram_ren;
    // Reads only happen in READY, so mem_we here is always a client commit.
    assign byp_hit   = rd_en && mem_we && (mem_waddr == ram_raddr);

    lc_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (rd_en),
        .raddr_i (ram_raddr),
        .rdata_o (core_rdata)
    );

    // Read pipeline: valid, bypass capture and a resettable copy of the
    // output so ram_rdata is 0 out of reset and holds between reads.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rvalid_q   <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            hold_q     <= '0;
        end else begin
            rvalid_q <= rd_en;
            byp_q    <= byp_hit;
            if (byp_hit) begin
                byp_data_q <= mem_wdata;
            end
            hold_q <= ram_rdata;
        end
    end

    assign ram_rvalid = rvalid_q;
    assign ram_rdata  = rvalid_q ? (byp_q ? byp_data_q : core_rdata) : hold_q;

endmodule

// File: tb/tb_lc_ram_store.sv
// Randomised self-checking bench for lc_ram_store against an array model.
module tb_lc_ram_store;

    localparam int DW    = 12;
    localparam int AW    = 7;
    localparam int DEPTH = 128;
    localparam logic [DW-1:0] IV = 12'hABC;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_done;
    logic          ram_ren;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic          ram_rvalid;
    logic          wa_en;
    logic [AW-1:0] wa_addr;
    logic [DW-1:0] wa_data;
    logic          wa_ack;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_ack;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_rd;

    lc_ram_store #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .INIT_VALUE (IV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .init_done  (init_done),
        .ram_ren    (ram_ren),
        .ram_raddr  (ram_raddr),
        .ram_rdata  (ram_rdata),
        .ram_rvalid (ram_rvalid),
        .wa_en      (wa_en),
        .wa_addr    (wa_addr),
        .wa_data    (wa_data),
        .wa_ack     (wa_ack),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_ack     (wb_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until init_done, with clients hammering the store meanwhile.
    task automatic wait_init(input int exp_cycles);
        int n = 0;
        wa_en = 1'b1; wa_addr = 7'd5; wa_data = 12'h123;
        wb_en = 1'b1; wb_addr = 7'd6; wb_data = 12'h456;
        ram_ren = 1'b1; ram_raddr = 7'd5;
        while (!init_done && n < 400) begin
            #1;
            check("init_wa_ack", 32'(wa_ack), 32'd0);
            check("init_wb_ack", 32'(wb_ack), 32'd0);
            tick();
            n++;
            check("init_rvalid", 32'(ram_rvalid), 32'd0);
        end
        wa_en = 1'b0; wb_en = 1'b0; ram_ren = 1'b0;
        check("init_cycles", 32'(n), 32'(exp_cycles));
        for (int i = 0; i < DEPTH; i++) model[i] = IV;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        ram_ren = 1'b1; ram_raddr = a;
        tick();
        ram_ren = 1'b0;
        exp_rd = model[a];
        check("read_rvalid", 32'(ram_rvalid), 32'd1);
        check("read_data", 32'(ram_rdata), 32'(exp_rd));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          b_pend;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_data;
        logic          exp_wa, exp_wb, rd;

        reset = 1'b0;
        ram_ren = 1'b0; ram_raddr = '0;
        wa_en = 1'b1; wa_addr = 7'd5; wa_data = 12'h123;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        exp_rd = '0;
        tick(); tick();
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_rvalid", 32'(ram_rvalid), 32'd0);
        check("rst_rdata", 32'(ram_rdata), 32'd0);
        check("rst_wa_ack", 32'(wa_ack), 32'd0);
        check("rst_wb_ack", 32'(wb_ack), 32'd0);

        reset = 1'b1;
        wait_init(DEPTH);
        check("ready_init_done", 32'(init_done), 32'd1);
        check("ready_rdata_zero", 32'(ram_rdata), 32'd0);
        do_read(7'd0);
        do_read(7'd64);
        do_read(7'd127);
        do_read(7'd5);
        do_read(7'd6);
        tick();
        check("hold_rvalid", 32'(ram_rvalid), 32'd0);
        check("hold_rdata", 32'(ram_rdata), 32'(exp_rd));

        // A and B collide on address 10: A wins, B retries and overwrites.
        wa_en = 1'b1; wa_addr = 7'd10; wa_data = 12'h111;
        wb_en = 1'b1; wb_addr = 7'd10; wb_data = 12'h222;
        #1;
        check("coll_wa_ack", 32'(wa_ack), 32'd1);
        check("coll_wb_ack1", 32'(wb_ack), 32'd0);
        tick();
        model[10] = 12'h111;
        wa_en = 1'b0;
        #1;
        check("coll_wb_ack2", 32'(wb_ack), 32'd1);
        tick();
        model[10] = 12'h222;
        wb_en = 1'b0;
        do_read(7'd10);

        // Read-during-write bypass.
        wa_en = 1'b1; wa_addr = 7'd20; wa_data = 12'h3FF;
        ram_ren = 1'b1; ram_raddr = 7'd20;
        tick();
        wa_en = 1'b0; ram_ren = 1'b0;
        model[20] = 12'h3FF;
        exp_rd = 12'h3FF;
        check("byp_rvalid", 32'(ram_rvalid), 32'd1);
        check("byp_data", 32'(ram_rdata), 32'h3FF);
        tick();
        check("byp_rvalid_once", 32'(ram_rvalid), 32'd0);
        check("byp_hold", 32'(ram_rdata), 32'h3FF);

        // Random traffic; B holds its request until acked.
        b_pend = 1'b0; b_addr = '0; b_data = '0;
        for (int k = 0; k < 400; k++) begin
            wa_en   = ($urandom_range(0, 2) == 0);
            wa_addr = AW'($urandom_range(0, 15));
            wa_data = DW'($urandom);
            if (!b_pend && $urandom_range(0, 1) == 1) begin
                b_pend = 1'b1;
                b_addr = AW'($urandom_range(0, 15));
                b_data = DW'($urandom);
            end
            wb_en = b_pend; wb_addr = b_addr; wb_data = b_data;
            rd = ($urandom_range(0, 1) == 1);
            ram_ren = rd;
            ram_raddr = AW'($urandom_range(0, 15));
            #1;
            exp_wa = wa_en;
            exp_wb = wb_en && !wa_en;
            check("rnd_wa_ack", 32'(wa_ack), 32'(exp_wa));
            check("rnd_wb_ack", 32'(wb_ack), 32'(exp_wb));
            if (exp_wa) model[wa_addr] = wa_data;
            else if (exp_wb) begin
                model[wb_addr] = wb_data;
                b_pend = 1'b0;
            end
            if (rd) exp_rd = model[ram_raddr];
            tick();
            check("rnd_rvalid", 32'(ram_rvalid), 32'(rd));
            check("rnd_rdata", 32'(ram_rdata), 32'(exp_rd));
        end
        wa_en = 1'b0; wb_en = 1'b0; ram_ren = 1'b0;

        // Back-to-back sweep of the whole address range.
        for (int i = 0; i < DEPTH; i++) begin
            ram_ren = 1'b1; ram_raddr = AW'(i);
            tick();
            exp_rd = model[i];
            check("b2b_rvalid", 32'(ram_rvalid), 32'd1);
            check("b2b_rdata", 32'(ram_rdata), 32'(exp_rd));
        end
        ram_ren = 1'b0;

        // Reset, then reset again when the sweep reaches address 50.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("mid_init_done", 32'(init_done), 32'd0);
        end
        reset = 1'b0;
        tick();
        exp_rd = '0;
        check("rst2_init_done", 32'(init_done), 32'd0);
        check("rst2_rvalid", 32'(ram_rvalid), 32'd0);
        check("rst2_rdata", 32'(ram_rdata), 32'd0);
        reset = 1'b1;
        wait_init(DEPTH);
        do_read(7'd50);
        do_read(7'd100);
        do_read(7'd0);
        do_read(7'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
